feature_map_streamer: RTL
=========================

// Module: feature_map_streamer
// PURPOSE
// - Transmit side of the pooling pixel-stream interface: buffers one IMG_HEIGHT x IMG_WIDTH feature map.
// - On command, issues a one-cycle start_signal, then streams the buffered pixels in raster order (row 0 col 0 first).
// - Stream is pixel_valid + signed pixel_out; its outputs drive a pooling stage's start_signal / pixel_valid / pixel_in directly.
// - Sits between the convolution output writer (load side) and the pooling stage (stream side).
// PARAMETERS
// - IMG_WIDTH   30  pixels per row
// - IMG_HEIGHT  30  rows per frame
// - DATA_W      22  signed pixel width
// - Derived: NPIX = IMG_WIDTH*IMG_HEIGHT; PTR_W = $clog2(NPIX) (10 at defaults)
// PORTS
// - clk           in   1       single clock; all logic on posedge
// - rst           in   1       asynchronous, active-low reset
// - load_valid    in   1       load_data is a valid raster-order pixel this cycle
// - load_data     in   DATA_W  signed pixel to buffer
// - start         in   1       request to stream the buffered frame
// - hold          in   1       stream pause; honoured only with STREAM_HOLD_EN
// - start_signal  out  1       one-cycle frame-start pulse to downstream
// - pixel_valid   out  1       pixel_out valid this cycle
// - pixel_out     out  DATA_W  signed streamed pixel
// - frame_ready   out  1       NPIX pixels buffered; start will be accepted
// - busy          out  1       state != IDLE
// - load_err      out  1       sticky: a load was dropped
// - done_signal   out  1       one-cycle pulse after the last pixel
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, load_ptr=0, rd_ptr=0; all outputs 0. Buffer contents are not reset.
// - All outputs are registered.
// - FSM states: IDLE -> ARM -> STREAM -> DONE -> IDLE.
// - IDLE
//   - load_valid with !frame_ready: buf[load_ptr]<=load_data; load_ptr++.
//   - On the write with load_ptr==NPIX-1: frame_ready<=1 next cycle; load_ptr<=0.
//   - load_valid while frame_ready=1, or in any state other than IDLE: data dropped, load_err<=1.
//   - start && frame_ready -> ARM; load_err<=0.
//   - start while !frame_ready: ignored, no error.
//   - Same-cycle 900th load and start: start ignored (frame_ready still 0).
// - ARM: start_signal=1 for exactly this cycle; rd_ptr=0 -> STREAM. hold does not affect ARM.
// - STREAM
//   - Each cycle not held: pixel_valid<=1, pixel_out<=buf[rd_ptr], rd_ptr++.
//   - After issuing rd_ptr==NPIX-1 -> DONE.
// - DONE: done_signal=1 for one cycle, pixel_valid=0, frame_ready<=0 (frame consumed) -> IDLE.
// - Timing, start sampled at edge T, no hold:
//   - start_signal high in cycle T+1.
//   - pixel 0 valid in cycle T+2.
//   - pixel NPIX-1 valid in cycle T+NPIX+1.
//   - done_signal in cycle T+NPIX+2.
// - pixel_valid is never high in the same cycle as start_signal.
// - start while busy is ignored.
// - Width rules: pure passthrough, bit-exact, no arithmetic. pixel_out holds its last value when pixel_valid=0.
// - Reset mid-operation: outputs drop to 0 immediately. Frame is discarded (frame_ready=0); a full reload is required.
// CONFIGURATION
// - STREAM_HOLD_EN defined:
//   - hold=1 sampled in STREAM: no advance; pixel_valid<=0 next cycle; rd_ptr frozen.
//   - Resumes on the first cycle hold=0; no pixel is skipped or duplicated.
//   - done_signal is delayed by the number of held cycles.
// - STREAM_HOLD_EN undefined: hold is ignored; the stream is always NPIX contiguous valid cycles.
// TESTING
// - Load 900 pixels, value=index; start at T -> start_signal only at T+1; pixel_valid T+2..T+901 with values 0..899 in order; done_signal at T+902; frame_ready=0 after.
// - Load 899 pixels, start -> no start_signal, busy=0. Load the 900th, start -> normal stream.
// - load_valid during STREAM -> load_err=1, streamed values unchanged; next accepted start clears load_err.
// - (STREAM_HOLD_EN) hold=1 for stream cycles 10..14 -> pixel_valid low for 5 cycles, values continue 10,11..., done delayed by 5.
// - rst=0 at pixel 400 -> pixel_valid/start_signal/done_signal/frame_ready=0 immediately; start after release is ignored until 900 new loads.
// - Pixels -2097152, 2097151, -1 -> reproduced bit-exact on pixel_out.

Source files
------------

// File: rtl/feature_map_streamer.sv
`default_nettype none
// =============================================================================
// Module   : feature_map_streamer
// Brief    : Buffers one feature map and streams it in raster order to a pooling
//            stage. Optional stream pause via macro STREAM_HOLD_EN.
// Revision : 1.0 - initial release
// =============================================================================
module feature_map_streamer #(
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int DATA_W     = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic signed [DATA_W-1:0] load_data,
  input  logic                     start,
  input  logic                     hold,
  output logic                     start_signal,
  output logic                     pixel_valid,
  output logic signed [DATA_W-1:0] pixel_out,
  output logic                     frame_ready,
  output logic                     busy,
  output logic                     load_err,
  output logic                     done_signal
);

  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int PTR_W = $clog2(NPIX);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [PTR_W-1:0]         r_load_ptr, w_load_ptr_nxt;
  logic [PTR_W-1:0]         r_rd_ptr, w_rd_ptr_nxt;
  logic signed [DATA_W-1:0] r_mem [NPIX];
  logic signed [DATA_W-1:0] r_pixel_out;
  logic r_start_signal, w_start_signal_nxt;
  logic r_pixel_valid, w_pixel_valid_nxt;
  logic r_frame_ready, w_frame_ready_nxt;
  logic r_busy, r_load_err, w_load_err_nxt;
  logic r_done, w_done_nxt;
  logic w_wr, w_issue, w_hold;

`ifdef STREAM_HOLD_EN
  assign w_hold = hold;
`else
  logic w_unused_hold;
  assign w_hold        = 1'b0;
  assign w_unused_hold = hold;
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_load_ptr_nxt     = r_load_ptr;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_start_signal_nxt = 1'b0;
    w_pixel_valid_nxt  = 1'b0;
    w_done_nxt         = 1'b0;
    w_frame_ready_nxt  = r_frame_ready;
    w_load_err_nxt     = r_load_err;
    w_wr               = 1'b0;
    w_issue            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && r_frame_ready) begin
          w_state_nxt        = S_ARM;
          w_start_signal_nxt = 1'b1;
          w_load_err_nxt     = 1'b0;
          w_rd_ptr_nxt       = '0;
        end
        if (load_valid) begin
          if (r_frame_ready) begin
            w_load_err_nxt = 1'b1;
          end else begin
            w_wr = 1'b1;
            if (r_load_ptr == c_last_ptr) begin
              w_load_ptr_nxt    = '0;
              w_frame_ready_nxt = 1'b1;
            end else begin
              w_load_ptr_nxt = r_load_ptr + 1'b1;
            end
          end
        end
      end
      // Pixel 0 is issued on the ARM exit edge so it follows start_signal directly.
      S_ARM: begin
        w_issue     = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_issue = !w_hold;
      end
      S_DONE: begin
        w_done_nxt        = 1'b1;
        w_frame_ready_nxt = 1'b0;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (load_valid && (r_state != S_IDLE)) begin
      w_load_err_nxt = 1'b1;
    end
    if (w_issue) begin
      w_pixel_valid_nxt = 1'b1;
      if (r_rd_ptr == c_last_ptr) begin
        w_state_nxt = S_DONE;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_load_ptr     <= '0;
      r_rd_ptr       <= '0;
      r_start_signal <= 1'b0;
      r_pixel_valid  <= 1'b0;
      r_pixel_out    <= '0;
      r_frame_ready  <= 1'b0;
      r_busy         <= 1'b0;
      r_load_err     <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_load_ptr     <= w_load_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_start_signal <= w_start_signal_nxt;
      r_pixel_valid  <= w_pixel_valid_nxt;
      r_frame_ready  <= w_frame_ready_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_load_err     <= w_load_err_nxt;
      r_done         <= w_done_nxt;
      if (w_issue) begin
        r_pixel_out <= r_mem[r_rd_ptr];
      end
    end
  end

  // Frame buffer has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_load_ptr] <= load_data;
    end
  end

  assign start_signal = r_start_signal;
  assign pixel_valid  = r_pixel_valid;
  assign pixel_out    = r_pixel_out;
  assign frame_ready  = r_frame_ready;
  assign busy         = r_busy;
  assign load_err     = r_load_err;
  assign done_signal  = r_done;

endmodule
`default_nettype wire
